crc32_stream: RTL
=================

CRC32_STREAM -- requirements
Module: crc32_stream

Interface
REQ-001 SHALL have parameter POLY, default 32'hEDB88320, reflected CRC-32 polynomial.
REQ-002 SHALL have parameter INIT, default 32'hFFFFFFFF, CRC register value at frame start.
REQ-003 SHALL have parameter XOROUT, default 32'hFFFFFFFF, value XORed into the final CRC register.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  in_data/in_last are valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a byte this cycle.
REQ-008 SHALL have port in_data  input  8  message byte, LSB-first CRC order.
REQ-009 SHALL have port in_last  input  1  marks the final byte of a frame.
REQ-010 SHALL have port out_valid  output  1  out_crc/out_len hold a finished frame result.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port out_crc  output  32  final CRC of the frame.
REQ-013 SHALL have port out_len  output  16  frame byte count, saturating.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-015 SHALL define a byte transfer as in_valid && in_ready on a rising clk edge.
REQ-016 SHALL drive in_ready = 1 in IDLE and ACCUM, and in_ready = 0 in DONE.
REQ-017 SHALL drive out_valid = 1 only in DONE.
REQ-018 SHALL compute one full byte update per transfer, with no multi-cycle iteration.
- Byte update: c = crc ^ {24'h0, in_data}.
- Then apply 8 rounds of c = (c >> 1) ^ (c[0] ? POLY : 0).
REQ-019 SHALL use INIT as the update's input crc for a transfer in IDLE, and the running CRC register for a transfer in ACCUM.
REQ-020 SHALL handle a transfer with in_last = 0 as follows:
- Store the updated CRC in the running register.
- Go to ACCUM, or stay in ACCUM.
REQ-021 SHALL handle a transfer with in_last = 1 as follows:
- Register out_crc = updated CRC ^ XOROUT.
- Go to DONE.
- Result appears on out_crc the cycle after the last byte (latency 1).
REQ-022 SHALL make length counting per frame:
- A transfer in IDLE sets the count to 1.
- Each later transfer increments the count.
- The count saturates at 16'hFFFF, with no wrap to 0.
- out_len equals the count including the last byte.
REQ-023 SHALL hold state, running CRC, and count unchanged in IDLE/ACCUM on cycles with no transfer; bubbles are allowed.
REQ-024 SHALL hold out_crc and out_len stable in DONE while out_valid && !out_ready.
REQ-025 SHALL go to IDLE on out_valid && out_ready.
- out_valid drops the next cycle.
- in_ready rises the same next cycle.
- Minimum gap between the last byte of one frame and the first byte of the next: 2 cycles.
REQ-026 SHALL ignore inputs while in DONE, including in_valid, in_data and in_last.
REQ-027 SHALL NOT combinationally depend in_ready on in_valid, or out_valid on out_ready.
REQ-028 SHALL make a 1-byte frame (in_last = 1 on the first byte) produce the single-byte CRC-32 of that byte.

Reset
REQ-029 SHALL, on any rising edge with rst = 1 and in any state, set:
- state = IDLE
- running CRC = INIT
- count = 0
- out_crc = 0
- out_len = 0
- out_valid = 0
REQ-030 SHALL drive in_ready = 1 on the first cycle after rst deasserts.
REQ-031 SHALL make reset mid-frame or in DONE discard the partial frame or pending result, with no output produced.
REQ-032 SHALL make rst take priority over a simultaneous transfer or out handshake.

Verification
REQ-033 SHALL verify: bytes "123456789" (0x31..0x39), last on 0x39, out_ready=1 -> out_crc=32'hCBF43926, out_len=9.
REQ-034 SHALL verify: single byte 0x00 with last -> out_crc=32'hD202EF8D, out_len=1; single byte 0x61 -> out_crc=32'hE8B7BE43, out_len=1.
REQ-035 SHALL verify: "123456789" with random in_valid bubbles, and out_ready held low 5 cycles -> result 32'hCBF43926 stable all 5 cycles, in_ready=0 throughout.
REQ-036 SHALL verify: back-to-back frames 0x61 then "123456789" -> results E8B7BE43 then CBF43926, and the second frame uses INIT, not the first frame's CRC.
REQ-037 SHALL verify: rst pulsed after 4 bytes of "123456789", then the full string sent -> only one result, CBF43926, out_len=9.
REQ-038 SHALL verify: a 70000-byte frame of 0x00 -> out_len=16'hFFFF, and out_crc matches the software model.

Source files
------------

// File: rtl/crc32_stream.sv
// Streaming CRC-32 engine: one byte per transfer, result and byte count are
// registered when the last byte is accepted and held until the consumer takes them.
module crc32_stream #(
  parameter logic [31:0] POLY   = 32'hEDB88320,
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_crc,
  output logic [15:0] out_len,
  output logic [1:0]  dbg_state
);

  // Handshakes: a beat moves on a rising edge where valid && ready. in_ready
  // and out_valid come from state only, never from in_valid or out_ready.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] crc_base, crc_upd;
  logic [31:0] out_crc_q, out_crc_d;
  logic [15:0] cnt_q, cnt_d, cnt_upd;
  logic [15:0] out_len_q, out_len_d;
  logic        xfer;

  function automatic logic [31:0] byte_update(input logic [31:0] crc,
                                              input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ (c[0] ? POLY : 32'h0);
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (xfer) begin
          state_d = in_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != DONE);
    out_valid = (state_q == DONE);
    dbg_state = state_q;
  end

  assign xfer = in_valid && in_ready;

  // A transfer in IDLE starts a new frame, so it seeds from INIT and a count of 1.
  always_comb begin
    crc_base  = (state_q == IDLE) ? INIT : crc_q;
    crc_upd   = byte_update(crc_base, in_data);
    cnt_upd   = (state_q == IDLE) ? 16'd1 :
                (cnt_q == 16'hFFFF) ? 16'hFFFF : cnt_q + 16'd1;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    out_crc_d = out_crc_q;
    out_len_d = out_len_q;
    if (xfer) begin
      cnt_d = cnt_upd;
      if (in_last) begin
        crc_d     = INIT;
        out_crc_d = crc_upd ^ XOROUT;
        out_len_d = cnt_upd;
      end else begin
        crc_d = crc_upd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q     <= INIT;
      cnt_q     <= 16'd0;
      out_crc_q <= 32'd0;
      out_len_q <= 16'd0;
    end else begin
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      out_crc_q <= out_crc_d;
      out_len_q <= out_len_d;
    end
  end

  assign out_crc = out_crc_q;
  assign out_len = out_len_q;

endmodule
